// File: rtl/imem_pkg.sv
// imem_pkg: shared instruction-memory types, sizes and the big-endian byte-lane order
//   IMEM_WORD_BYTES  bytes per instruction word
//   IMEM_ADDR_W      default byte-address width
//   imem_ld_state_t  loader FSM states
//   imem_byte_lane   byte i of a word, lane 0 = MSB = lowest address
package imem_pkg;
  localparam int IMEM_WORD_BYTES = 4;
  localparam int IMEM_ADDR_W = 8;
  typedef enum logic [1:0] {
    IMEM_IDLE  = 2'd0,
    IMEM_LOAD  = 2'd1,
    IMEM_WRITE = 2'd2,
    IMEM_DONE  = 2'd3
  } imem_ld_state_t;
  function automatic logic [7:0] imem_byte_lane(input logic [31:0] w, input logic [1:0] i);
    return i == 2'd0 ? w[31:24] : i == 2'd1 ? w[23:16] : i == 2'd2 ? w[15:8] : w[7:0];
  endfunction
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: word stream in and byte write bus out of the instruction-memory loader
//   word_valid/word_data/word_last/word_ready  32-bit word stream (source -> loader)
//   mem_we/mem_addr/mem_wdata                  byte write port (loader -> memory)
//   modport slave: loader side; modport master: source/memory side
interface imem_loader_if import imem_pkg::*; #(parameter int ADDR_W = IMEM_ADDR_W);
  logic              word_valid;
  logic [31:0]       word_data;
  logic              word_last;
  logic              word_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  modport slave (
    input  word_valid, word_data, word_last,
    output word_ready, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output word_valid, word_data, word_last,
    input  word_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_byte_serializer.sv
// imem_byte_serializer: holds a captured word and byte index, presents the current big-endian byte
//   clk, reset   clock, async active-low reset
//   load_i       capture data_i and restart at byte 0
//   adv_i        step to the next byte
//   data_i       word to capture
//   byte_o       registered byte for the current index
//   last_byte_o  current index is the final byte of the word
module imem_byte_serializer import imem_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        adv_i,
  input  logic [31:0] data_i,
  output logic [7:0]  byte_o,
  output logic        last_byte_o
);
  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  byte_q, byte_d;
  always_comb begin
    word_d = load_i ? data_i : word_q;
    idx_d  = load_i ? 2'd0 : adv_i ? idx_q + 2'd1 : idx_q;
    // the byte register is loaded with the lane for the index being entered
    byte_d = load_i ? imem_byte_lane(data_i, 2'd0) : adv_i ? imem_byte_lane(word_q, idx_d) : byte_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q <= '0;
      idx_q  <= '0;
      byte_q <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
      byte_q <= byte_d;
    end
  end
  assign byte_o      = byte_q;
  assign last_byte_o = idx_q == 2'(IMEM_WORD_BYTES - 1);
endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer of 32-bit words as four big-endian bytes into byte-wide imem
//   clk, reset   clock, async active-low reset
//   start        begin a load session (honored in IDLE only)
//   bus          imem_loader_if.slave: word stream in, byte write port out
//   busy         not IDLE
//   done         one-cycle completion pulse
//   wrap_err     sticky: byte address wrapped past the top of memory, cleared by start
//   word_count   words written this session
//   checksum     sum of accepted words (only with IMEM_LOADER_CHECKSUM_EN defined)
module imem_loader import imem_pkg::*; #(
  parameter int                ADDR_W    = IMEM_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  imem_loader_if.slave      bus,
  output logic              busy,
  output logic              done,
  output logic              wrap_err,
  output logic [ADDR_W-2:0] word_count
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);
  localparam logic [1:0] S_IDLE  = IMEM_IDLE;
  localparam logic [1:0] S_LOAD  = IMEM_LOAD;
  localparam logic [1:0] S_WRITE = IMEM_WRITE;
  localparam logic [1:0] S_DONE  = IMEM_DONE;
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-2:0] count_q, count_d;
  logic              wrap_q, wrap_d;
  logic              last_q, last_d;
  logic              ready_q, we_q, busy_q, done_q;
  logic              go, hs, writing, last_byte;
  logic [7:0]        byte_w;
  assign go      = state_q == S_IDLE && start;
  assign hs      = state_q == S_LOAD && bus.word_valid;
  assign writing = state_q == S_WRITE;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    wrap_d  = wrap_q;
    last_d  = last_q;
    if (go) begin
      state_d = S_LOAD;
      addr_d  = BASE_ADDR;
      count_d = '0;
      wrap_d  = 1'b0;
    end
    if (hs) begin
      state_d = S_WRITE;
      last_d  = bus.word_last;
    end
    if (writing) begin
      addr_d = addr_q + 1'b1;
      wrap_d = wrap_q | (&addr_q);
      if (last_byte) begin
        // word count wraps at the number of words the memory holds
        count_d = {1'b0, count_q[ADDR_W-3:0] + 1'b1};
        state_d = last_q ? S_DONE : S_LOAD;
      end
    end
    if (state_q == S_DONE) state_d = S_IDLE;
  end
  // status outputs are registered from the next state so they change in step with it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= BASE_ADDR;
      count_q <= '0;
      wrap_q  <= 1'b0;
      last_q  <= 1'b0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      last_q  <= last_d;
      ready_q <= state_d == S_LOAD;
      we_q    <= state_d == S_WRITE;
      busy_q  <= state_d != S_IDLE;
      done_q  <= state_d == S_DONE;
    end
  end
  imem_byte_serializer u_ser (
    .clk        (clk),
    .reset      (reset),
    .load_i     (hs),
    .adv_i      (writing),
    .data_i     (bus.word_data),
    .byte_o     (byte_w),
    .last_byte_o(last_byte)
  );
  assign bus.word_ready = ready_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = byte_w;
  assign busy           = busy_q;
  assign done           = done_q;
  assign wrap_err       = wrap_q;
  assign word_count     = count_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] cks_q, cks_d;
  assign cks_d = go ? '0 : hs ? cks_q + bus.word_data : cks_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cks_q <= '0;
    else cks_q <= cks_d;
  end
  assign checksum = cks_q;
`endif
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the byte-addressed instruction memory: accepts 32-bit instruction words over a valid/ready stream and writes each as four big-endian bytes (MSB at lowest address) into the 8-bit-wide memory array, one byte per cycle. It is the write side of the fetch path, whose reader assembles `{mem[a], mem[a+1], mem[a+2], mem[a+3]}`. It runs while the core is held idle, then signals completion.

## Interface
- `ADDR_W`, 8, byte-address width; memory depth is 2^ADDR_W bytes.
- `BASE_ADDR`, 0, first byte address of a load session; must be a multiple of 4.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset; one clock domain only.
- `start`  in  1  single-cycle request to begin a load session; honored only in IDLE.
- `word_valid`  in  1  source has a word on `word_data`.
- `word_data`  in  32  instruction word.
- `word_last`  in  1  qualifies the accepted word as the final word of the session.
- `word_ready`  out  1  loader accepts a word this cycle.
- `mem_we`  out  1  byte write strobe.
- `mem_addr`  out  ADDR_W  byte address.
- `mem_wdata`  out  8  byte data.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when the session completes.
- `wrap_err`  out  1  sticky: byte address wrapped past 2^ADDR_W−1; cleared by `start`.
- `word_count`  out  ADDR_W−1  words written this session, modulo 2^(ADDR_W−2).

## Operation
- States: IDLE, LOAD, WRITE, DONE.
- IDLE: `word_ready`=0 and `mem_we`=0. On `start`, load the address counter with BASE_ADDR, clear `word_count` and `wrap_err`, then go to LOAD.
- LOAD: `word_ready`=1. On `word_valid & word_ready`, capture `word_data` and `word_last`, reset the byte index to 0, then go to WRITE.
- WRITE: 4 cycles, byte index 0..3. `mem_we`=1, `mem_wdata` = `word[31-8*i -: 8]`, `mem_addr` = counter. The counter increments after each byte. After byte 3, `word_count` increments, then go to DONE if the captured last flag is set, else to LOAD.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Address arithmetic is modulo 2^ADDR_W. An increment from 2^ADDR_W−1 to 0 sets `wrap_err`, and writing continues.
- `start` is ignored in any state other than IDLE. `word_valid` is ignored outside LOAD.
- `word_data` and `word_last` are sampled only on the handshake cycle; the source may change them afterwards.
- Reset mid-session: all state returns to reset values immediately. Partially written memory contents are not undone.

## Timing
- Reset values: `word_ready`=0, `mem_we`=0, `mem_addr`=BASE_ADDR, `mem_wdata`=0, `busy`=0, `done`=0, `wrap_err`=0, `word_count`=0, state IDLE.
- All outputs are registered.
- `start` sampled at edge N: `busy` and `word_ready` are high from N+1.
- Handshake at edge K: `mem_we` is high for cycles K+1..K+4 with addresses A..A+3. `word_ready` returns high at K+5 if the word was not last.
- Throughput is one word per 5 cycles with a continuously valid source.
- Last word accepted at K: `done` is high in cycle K+5 and `busy` drops at K+6.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined: adds output `checksum` (32 bits). It is the sum modulo 2^32 of all accepted words, cleared on `start`, updated on each handshake, stable from the `done` cycle until the next `start`, and reset to 0.
- Macro undefined: the `checksum` port and its adder are absent. All other behaviour is identical.

## Structure
- Shared package `imem_pkg`:
  - state enum `imem_ld_state_t`
  - `IMEM_WORD_BYTES` = 4
  - default `IMEM_ADDR_W` = 8
- The same package defines the big-endian lane order used by both the reader and the loader.
- One sub-module, `imem_byte_serializer`: holds the captured word and the byte index, and emits the byte for the current index.
- The FSM, counters and error flag stay in the top level.

## Test plan
- Reset asserted mid-WRITE → all outputs return to reset values asynchronously. A later `start` begins again at BASE_ADDR.
- Single word 0x8C220004 with last=1 after `start` → writes 8C, 22, 00, 04 at addresses 0..3 on consecutive cycles. `done` pulses at K+5, `word_count`=1, and a reader at address 0 returns 0x8C220004.
- Three words with `word_valid` deasserted for 3 cycles between words → `word_ready` is held high through the gaps. Addresses 0..11 are written in order and `done` pulses after the third word only.
- `BASE_ADDR`=252 with two words → second word lands at 0..3, `wrap_err`=1 after `done`, and `wrap_err` clears on the next `start`.
- `start` pulsed during WRITE, and `word_valid` held high in IDLE → no effect and no handshake.
- With `IMEM_LOADER_CHECKSUM_EN`: words 0xFFFFFFFF and 0x00000002 → `checksum`=0x00000001 at `done`.
